// File: rtl/sender_arbiter_pkg.sv
// Shared definitions for the sender arbiter.
//   - state_e: FSM encoding (StHeader only reachable with SENDER_ARB_HEADER_EN)
//   - default sizing constants
//   - header byte layout: {grant[2:0], 2'b00, len[2:0]}
package sender_arbiter_pkg;

  localparam int unsigned SENDER_ARB_N_REQ     = 2;
  localparam int unsigned SENDER_ARB_MAX_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeader = 2'd1,
    StSend   = 2'd2
  } state_e;

  localparam int unsigned HdrGrantLsb = 5;
  localparam int unsigned HdrGrantW   = 3;
  localparam int unsigned HdrLenLsb   = 0;
  localparam int unsigned HdrLenW     = 3;

  function automatic logic [7:0] hdr_byte(logic [HdrGrantW-1:0] grant, logic [HdrLenW-1:0] len);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[HdrGrantLsb +: HdrGrantW] = grant;
    hdr[HdrLenLsb +: HdrLenW]     = len;
    return hdr;
  endfunction

endpackage

// File: rtl/sender_arbiter_rr_arbiter.sv
// Round-robin priority pick (rr_arbiter), purely combinational.
// Ports:
//   req         - request vector
//   last_grant  - index of the previous winner; search starts just after it
//   grant       - one-hot winner (all zero when no request)
//   grant_idx   - binary index of the winner
//   grant_valid - at least one request present
module sender_arbiter_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [GW-1:0]    grant_idx,
  output logic             grant_valid
);

  always_comb begin
    logic [GW-1:0] cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = last_grant;
    // Walk N_REQ candidates starting at last_grant+1, wrapping at N_REQ-1.
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (cand == GW'(N_REQ - 1)) ? '0 : cand + GW'(1);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sender_arbiter.sv
// Shares one byte-wide transmit path between N_REQ requesters. Each granted word
// (1..MAX_BYTES bytes, LSB first) is sent atomically; grants are round-robin.
// Optional macro SENDER_ARB_HEADER_EN: prefix each packet with one header byte
// {grant[2:0], 2'b00, len[2:0]}.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester word pending
//   req_data   - per-requester word, requester i at [i*8*MAX_BYTES +: 8*MAX_BYTES]
//   req_len    - per-requester byte count minus one
//   req_ready  - one-hot accept pulse, only in IDLE
//   out        - byte to the sender, qualified by out_valid / out_ready
//   busy       - packet in flight
module sender_arbiter
  import sender_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = SENDER_ARB_N_REQ,
  parameter int unsigned MAX_BYTES = SENDER_ARB_MAX_BYTES,
  localparam int unsigned DW       = 8 * MAX_BYTES,
  localparam int unsigned LW       = $clog2(MAX_BYTES),
  localparam int unsigned GW       = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*LW-1:0] req_len,
  output logic [N_REQ-1:0]    req_ready,
  output logic [7:0]          out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

`ifdef SENDER_ARB_HEADER_EN
  localparam state_e StAfterGrant = StHeader;
`else
  localparam state_e StAfterGrant = StSend;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [GW-1:0] last_q, last_d;

  logic [N_REQ-1:0] grant_oh;
  logic [GW-1:0]    grant_idx;
  logic             grant_valid;
  logic [DW-1:0]    sel_data;
  logic [LW-1:0]    sel_len;
  logic [LW-1:0]    len_clamped;
  logic [7:0]       cur_byte;

  sender_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_q),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_data = req_data[i*DW +: DW];
        sel_len  = req_len[i*LW +: LW];
      end
    end
  end

  // Only a non-power-of-2 MAX_BYTES leaves len codes beyond the last byte.
  if ((1 << LW) != MAX_BYTES) begin : g_clamp
    localparam logic [LW-1:0] LenMax = LW'(MAX_BYTES - 1);
    assign len_clamped = (sel_len > LenMax) ? LenMax : sel_len;
  end else begin : g_no_clamp
    assign len_clamped = sel_len;
  end

  always_comb begin
    cur_byte = data_q[7:0];
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (idx_q == LW'(b)) cur_byte = data_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    last_d    = last_q;
    req_ready = '0;
    out       = 8'h00;
    out_valid = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          req_ready = grant_oh;
          data_d    = sel_data;
          len_d     = len_clamped;
          idx_d     = '0;
          last_d    = grant_idx;
          state_d   = StAfterGrant;
        end
      end
`ifdef SENDER_ARB_HEADER_EN
      StHeader: begin
        out       = hdr_byte(3'(last_q), 3'(len_q));
        out_valid = 1'b1;
        if (out_ready) state_d = StSend;
      end
`endif
      StSend: begin
        out       = cur_byte;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == len_q) state_d = StIdle;
          else                idx_d   = idx_q + LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      last_q  <= GW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sender_arbiter.sv
`timescale 1ns/1ps
module tb_sender_arbiter;

  localparam int N_REQ     = 2;
  localparam int MAX_BYTES = 4;
`ifdef SENDER_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*8*MAX_BYTES-1:0] req_data;
  logic [N_REQ*2-1:0]          req_len;
  logic [N_REQ-1:0]            req_ready;
  logic [7:0]                  out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  always #5 clk = ~clk;

  sender_arbiter #(
    .N_REQ     (N_REQ),
    .MAX_BYTES (MAX_BYTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_len   (req_len),
    .req_ready (req_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cycle   = 0;
  int g;
  logic [7:0] exp_q[$];
  int         exp_g[$];
  int         gcyc_q[$];
  logic [15:0] bp_pat = 16'b1010_1100_0110_1001;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cycle);
  endtask

  // Expected bytes (optionally only the first 'keep') and the grant for one word.
  task automatic push_word(input int r, input logic [31:0] d, input int len, input int keep);
    logic [7:0] b[$];
    logic [2:0] rr, ll;
    logic [7:0] h;
    if (HDR != 0) begin
      rr = r[2:0];
      ll = len[2:0];
      h  = {rr, 2'b00, ll};
      b.push_back(h);
    end
    for (int k = 0; k <= len; k++) b.push_back(d[8*k +: 8]);
    for (int k = 0; k < b.size() && k < keep; k++) exp_q.push_back(b[k]);
    exp_g.push_back(r);
  endtask

  // Raise a word, wait (bounded) for its accept, return just after the accepting edge.
  task automatic issue(input int r, input logic [31:0] d, input logic [1:0] l);
    bit got = 1'b0;
    req_data[r*32 +: 32] = d;
    req_len[r*2 +: 2]    = l;
    req_valid[r]         = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    check("issue_accept", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic drop(input int r);
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_g.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor / scoreboard.
  logic [7:0]       prev_out   = '0;
  logic             prev_stall = 1'b0;
  logic [N_REQ-1:0] prev_valid = '0;
  logic [N_REQ-1:0] prev_ready = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_out", out, prev_out);
        check("hold_valid", out_valid, 1);
      end
      if (|req_ready) begin
        check("ready_in_idle", busy, 0);
        if (exp_g.size() == 0) check("grant_unexpected", req_ready, 0);
        else begin
          g = exp_g.pop_front();
          check("grant", req_ready, 32'(1 << g));
          gcyc_q.push_back(cycle);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (prev_valid[i] && !req_valid[i]) check("req_hold", prev_ready[i], 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("byte_unexpected", out, 0);
        else check("byte", out, exp_q.pop_front());
      end
    end
    prev_stall <= !rst && out_valid && !out_ready;
    prev_out   <= out;
    prev_valid <= rst ? '0 : req_valid;
    prev_ready <= req_ready;
  end

  initial begin
    int hs;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;

    // Single word with cycle-exact latency.
    push_word(0, 32'h44332211, 3, 99);
    req_data[31:0] = 32'h44332211;
    req_len[1:0]   = 2'd3;
    req_valid[0]   = 1'b1;
    @(negedge clk);
    check("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int k = 0; k < 4 + HDR; k++) begin
      @(negedge clk);
      check("t1_valid", out_valid, 1);
    end
    @(negedge clk);
    check("t1_busy_end", busy, 0);
    @(posedge clk); #1;
    drain();

    // Backpressure.
    push_word(0, 32'h44332211, 3, 99);
    fork
      begin issue(0, 32'h44332211, 2'd3); drop(0); end
      begin
        for (int k = 0; k < 16; k++) begin
          out_ready = bp_pat[k];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Late arrival: req1 must wait for req0's last byte.
    push_word(0, 32'h0D0C0B0A, 3, 99);
    push_word(1, 32'h00000077, 0, 99);
    gcyc_q.delete();
    fork
      begin issue(0, 32'h0D0C0B0A, 2'd3); drop(0); end
      begin
        repeat (2) begin @(posedge clk); #1; end
        issue(1, 32'h00000077, 2'd0);
        drop(1);
      end
    join
    drain();
    check("late_gap", gcyc_q[1] - gcyc_q[0], 5 + HDR);

    // Round-robin with both requesters continuously valid.
    push_word(0, 32'h000000AA, 0, 99);
    push_word(1, 32'h000000BB, 0, 99);
    push_word(0, 32'h000000AA, 0, 99);
    push_word(1, 32'h000000BB, 0, 99);
    gcyc_q.delete();
    fork
      begin issue(0, 32'hAA, 2'd0); issue(0, 32'hAA, 2'd0); drop(0); end
      begin issue(1, 32'hBB, 2'd0); issue(1, 32'hBB, 2'd0); drop(1); end
    join
    drain();
    for (int k = 1; k < 4; k++) check("rr_gap", gcyc_q[k] - gcyc_q[k-1], 2 + HDR);

    // Reset mid-packet after two delivered bytes.
    push_word(0, 32'h44332211, 3, 2);
    issue(0, 32'h44332211, 2'd3);
    drop(0);
    hs = 0;
    for (int k = 0; k < 50 && hs < 2; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
    end
    check("mid_handshakes", hs, 2);
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    push_word(0, 32'h00000055, 0, 99);
    push_word(1, 32'h00000066, 0, 99);
    fork
      begin issue(0, 32'h55, 2'd0); drop(0); end
      begin issue(1, 32'h66, 2'd0); drop(1); end
    join
    drain();

`ifdef SENDER_ARB_HEADER_EN
    exp_q.push_back(8'h21);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    exp_g.push_back(1);
    issue(1, 32'h0000BEEF, 2'd1);
    drop(1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
